// File: rtl/match_detect_reg.sv
// Registered compare of a running value against a loadable target, with level,
// rising-edge pulse, sticky flag and saturating hit counter outputs.
module match_detect_reg #(
  parameter int WIDTH = 13,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load_target,
  input  logic [WIDTH-1:0] target_in,
  input  logic [WIDTH-1:0] value,
  input  logic             clear,
  output logic [WIDTH-1:0] target_q,
  output logic             match,
  output logic             match_pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    MODE_EQ = 2'b00,
    MODE_NE = 2'b01,
    MODE_GE = 2'b10,
    MODE_LT = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_target;
  logic             r_match;
  logic             r_pulse;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;

  logic             w_cmp;
  logic             w_rise;
  logic             w_cnt_max;

  // The compare sees the target as it stood before any load in this cycle.
  always_comb begin
    w_cmp = 1'b0;
    case (mode_e'(mode))
      MODE_EQ: w_cmp = (value == r_target);
      MODE_NE: w_cmp = (value != r_target);
      MODE_GE: w_cmp = (value >= r_target);
      MODE_LT: w_cmp = (value <  r_target);
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_rise    = w_cmp & ~r_match;
  assign w_cnt_max = &r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target <= '0;
    end else if (load_target) begin
      r_target <= target_in;
    end
  end

  // clear beats en; with en low the level holds and no events are produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match  <= 1'b0;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (clear) begin
      r_match  <= 1'b0;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (en) begin
      r_match <= w_cmp;
      r_pulse <= w_rise;
      if (w_rise) begin
        r_sticky <= 1'b1;
        if (!w_cnt_max) begin
          r_count <= r_count + 1'b1;
        end
      end
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign target_q    = r_target;
  assign match       = r_match;
  assign match_pulse = r_pulse;
  assign sticky      = r_sticky;
  assign hit_count   = r_count;

endmodule

// File: tb/tb_match_detect_reg.sv
// Self-checking bench for match_detect_reg: a spec-level model checked every
// cycle on two instances (default counter width and a 2-bit counter).
module tb_match_detect_reg;

  localparam int WIDTH = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic             loadTarget;
  logic [WIDTH-1:0] targetIn;
  logic [WIDTH-1:0] value;
  logic             clear;

  logic [WIDTH-1:0] targetQ, targetQ2;
  logic             match, match2, matchPulse, matchPulse2, sticky, sticky2;
  logic [7:0]       hitCount;
  logic [1:0]       hitCount2;

  int checks   = 0;
  int failures = 0;
  bit chkEn    = 1'b0;

  int mTarget, mCount, mCount2;
  bit mMatch, mPulse, mSticky;

  match_detect_reg #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_target(loadTarget),
    .target_in(targetIn), .value(value), .clear(clear),
    .target_q(targetQ), .match(match), .match_pulse(matchPulse),
    .sticky(sticky), .hit_count(hitCount)
  );

  match_detect_reg #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_target(loadTarget),
    .target_in(targetIn), .value(value), .clear(clear),
    .target_q(targetQ2), .match(match2), .match_pulse(matchPulse2),
    .sticky(sticky2), .hit_count(hitCount2)
  );

  always #5 clk = ~clk;

  function automatic bit modelCmp(int m, int v, int t);
    case (m)
      0: return v == t;
      1: return v != t;
      2: return v >= t;
      default: return v < t;
    endcase
  endfunction

  // Reference behaviour: what each output must be after every clock edge.
  always @(posedge clk or posedge rst) begin
    bit cmpNow, rise;
    if (rst) begin
      mTarget <= 0; mMatch <= 0; mPulse <= 0; mSticky <= 0;
      mCount <= 0; mCount2 <= 0;
    end else begin
      cmpNow = modelCmp(int'(mode), int'(value), mTarget);
      rise   = cmpNow && !mMatch;
      if (loadTarget) mTarget <= int'(targetIn);
      if (clear) begin
        mMatch <= 0; mPulse <= 0; mSticky <= 0; mCount <= 0; mCount2 <= 0;
      end else if (en) begin
        mMatch <= cmpNow;
        mPulse <= rise;
        if (rise) begin
          mSticky <= 1;
          mCount  <= (mCount  + 1 > 255) ? 255 : mCount + 1;
          mCount2 <= (mCount2 + 1 > 3)   ? 3   : mCount2 + 1;
        end
      end else begin
        mPulse <= 0;
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("model target_q",    32'(targetQ),     32'(mTarget));
      checkOutput("model match",       32'(match),       32'(mMatch));
      checkOutput("model match_pulse", 32'(matchPulse),  32'(mPulse));
      checkOutput("model sticky",      32'(sticky),      32'(mSticky));
      checkOutput("model hit_count",   32'(hitCount),    32'(mCount));
      checkOutput("model2 match",      32'(match2),      32'(mMatch));
      checkOutput("model2 pulse",      32'(matchPulse2), 32'(mPulse));
      checkOutput("model2 hit_count",  32'(hitCount2),   32'(mCount2));
    end
  end

  // Drive one cycle of inputs, then return at the next falling edge.
  task automatic applyStimulus(bit e, logic [1:0] m, bit ld, int tin, int v, bit clr);
    en = e; mode = m; loadTarget = ld;
    targetIn = WIDTH'(tin); value = WIDTH'(v); clear = clr;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    int expCnt2[5] = '{1, 2, 3, 3, 3};
    rst = 1'b1; en = 0; mode = 0; loadTarget = 0; targetIn = 0; value = 0; clear = 0;
    @(negedge clk); @(negedge clk);
    checkOutput("reset match",     32'(match),     0);
    checkOutput("reset hit_count", 32'(hitCount),  0);
    checkOutput("reset target_q",  32'(targetQ),   0);
    rst = 1'b0;
    chkEn = 1'b1;

    $display("[TB] EQ sequence around 0x1ABC");
    applyStimulus(0, 2'b00, 1, 'h1ABC, 0, 0);
    checkOutput("eq target_q", 32'(targetQ), 'h1ABC);
    applyStimulus(1, 2'b00, 0, 0, 'h1ABB, 0);
    checkOutput("eq step0 match", 32'(match), 0);
    applyStimulus(1, 2'b00, 0, 0, 'h1ABC, 0);
    checkOutput("eq step1 match", 32'(match), 1);
    checkOutput("eq step1 pulse", 32'(matchPulse), 1);
    applyStimulus(1, 2'b00, 0, 0, 'h1ABC, 0);
    checkOutput("eq step2 match", 32'(match), 1);
    checkOutput("eq step2 pulse", 32'(matchPulse), 0);
    applyStimulus(1, 2'b00, 0, 0, 'h1ABD, 0);
    checkOutput("eq step3 match", 32'(match), 0);
    checkOutput("eq hit_count",   32'(hitCount), 1);
    checkOutput("eq sticky",      32'(sticky), 1);

    $display("[TB] load in same cycle as compare");
    applyStimulus(1, 2'b00, 1, 3, 0, 0);
    applyStimulus(1, 2'b00, 1, 7, 7, 0);
    checkOutput("load same-cycle match", 32'(match), 0);
    applyStimulus(1, 2'b00, 0, 0, 7, 0);
    checkOutput("load next-cycle match", 32'(match), 1);

    $display("[TB] GE ramp then LT");
    applyStimulus(0, 2'b10, 1, 100, 0, 1);
    pulses = 0;
    for (int v = 98; v <= 103; v++) begin
      applyStimulus(1, 2'b10, 0, 0, v, 0);
      checkOutput("ge ramp match", 32'(match), (v >= 100) ? 1 : 0);
      if (matchPulse) pulses++;
    end
    checkOutput("ge pulse count", 32'(pulses), 1);
    applyStimulus(1, 2'b11, 0, 0, 103, 0);
    checkOutput("lt match falls", 32'(match), 0);

    $display("[TB] saturating counter");
    applyStimulus(0, 2'b00, 1, 5, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 2'b00, 0, 0, 5, 0);
      checkOutput("sat hit_count2", 32'(hitCount2), 32'(expCnt2[i]));
      checkOutput("sat hit_count",  32'(hitCount),  32'(i + 1));
      if (i < 4) applyStimulus(1, 2'b00, 0, 0, 0, 0);
    end

    $display("[TB] async reset mid-run");
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst match",     32'(match),      0);
    checkOutput("async rst hit_count", 32'(hitCount),   0);
    checkOutput("async rst sticky",    32'(sticky),     0);
    checkOutput("async rst target_q",  32'(targetQ),    0);
    checkOutput("async rst pulse",     32'(matchPulse), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] clear with compare true");
    applyStimulus(0, 2'b00, 1, 5, 0, 0);
    applyStimulus(1, 2'b00, 0, 0, 5, 0);
    checkOutput("pre-clear match", 32'(match), 1);
    applyStimulus(1, 2'b00, 0, 0, 5, 1);
    checkOutput("clear match",     32'(match), 0);
    checkOutput("clear hit_count", 32'(hitCount), 0);
    checkOutput("clear sticky",    32'(sticky), 0);
    applyStimulus(1, 2'b00, 0, 0, 5, 0);
    checkOutput("post-clear match", 32'(match), 1);
    checkOutput("post-clear pulse", 32'(matchPulse), 1);
    checkOutput("post-clear count", 32'(hitCount), 1);
    applyStimulus(1, 2'b00, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 5, 0);
    checkOutput("en low match held", 32'(match), 0);
    checkOutput("en low no pulse",   32'(matchPulse), 0);
    applyStimulus(0, 2'b01, 0, 0, 0, 0);
    checkOutput("en low count held", 32'(hitCount), 1);

    applyStimulus(0, 2'b00, 0, 0, 0, 0);
    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
